// File: rtl/ddram_resp_pkg.sv
// rtl/ddram_resp_pkg.sv - shared types and widths for the DDRAM BRAM responder
package ddram_resp_pkg;

    localparam int DDR_ADDR_W = 29;
    localparam int DDR_DATA_W = 64;
    localparam int DDR_BE_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RLAT,
        RDATA
    } state_t;

    // A burst count of zero still moves one beat.
    function automatic logic [7:0] eff_burst(input logic [7:0] bc);
        return (bc == 8'd0) ? 8'd1 : bc;
    endfunction

endpackage

// File: rtl/ddram_bram_responder_if.sv
// rtl/ddram_bram_responder_if.sv - DDRAM_* burst bus; master = client, slave = responder
interface ddram_bram_responder_if;
    import ddram_resp_pkg::*;

    logic                  DDRAM_BUSY;
    logic [7:0]            DDRAM_BURSTCNT;
    logic [DDR_ADDR_W-1:0] DDRAM_ADDR;
    logic                  DDRAM_RD;
    logic                  DDRAM_WE;
    logic [DDR_DATA_W-1:0] DDRAM_DIN;
    logic [DDR_BE_W-1:0]   DDRAM_BE;
    logic [DDR_DATA_W-1:0] DDRAM_DOUT;
    logic                  DDRAM_DOUT_READY;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
    );

endinterface

// File: rtl/ddram_resp_mem.sv
// rtl/ddram_resp_mem.sv - simple dual-port BRAM, 64-bit words, byte write enables, registered read
// Ports: clk, rst_n (read register only); we/waddr/wdata/wbe write port; re/raddr/rdata read port.
module ddram_resp_mem
    import ddram_resp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DDR_DATA_W-1:0] wdata,
    input  logic [DDR_BE_W-1:0]   wbe,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DDR_DATA_W-1:0] rdata
);

    logic [DDR_DATA_W-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DDR_BE_W; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register holds its value between reads so the last beat stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ddram_bram_responder.sv
// rtl/ddram_bram_responder.sv - DDRAM_* burst responder backed by on-chip BRAM
// Ports: clk, rst_n (async active-low); bus (slave modport: BUSY/DOUT/DOUT_READY out,
// BURSTCNT/ADDR/RD/WE/DIN/BE in); err (sticky protocol/window error).
module ddram_bram_responder
    import ddram_resp_pkg::*;
#(
    parameter int          AW           = 10,
    parameter logic [3:0]  BASE_HI      = 4'b0011,
    parameter int          RD_LATENCY   = 3,
    parameter int          STALL_PERIOD = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ddram_bram_responder_if.slave  bus,
    output logic                   err
);

    state_t          state, state_nxt;
    logic [7:0]      beats_left;
    logic [AW-1:0]   addr_cnt;
    logic [13:0]     lat_sr;
    logic [15:0]     stall_cnt;
    logic            rd_oow, wr_oow;

    logic            in_win, stall, busy, ready;
    logic            wr_acc, rd_acc, err_set;
    logic            mem_we, mem_re;
    logic [AW-1:0]   mem_waddr;
    logic [63:0]     mem_q;
    logic [7:0]      bc_eff;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^bus.DDRAM_ADDR[24:AW];

    assign in_win = (bus.DDRAM_ADDR[28:25] == BASE_HI);
    assign bc_eff = eff_burst(bus.DDRAM_BURSTCNT);
    assign stall  = (STALL_PERIOD > 1) && (stall_cnt == 16'(STALL_PERIOD - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ready     = 1'b0;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        err_set   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = addr_cnt;
        case (state)
            IDLE: begin
                busy = stall;
                if (!stall) begin
                    if (bus.DDRAM_WE) begin
                        // Write wins; a simultaneous read is dropped and flagged.
                        wr_acc    = 1'b1;
                        mem_we    = in_win;
                        mem_waddr = bus.DDRAM_ADDR[AW-1:0];
                        err_set   = bus.DDRAM_RD | ~in_win;
                        if (bc_eff > 8'd1) state_nxt = WBURST;
                    end else if (bus.DDRAM_RD) begin
                        rd_acc    = 1'b1;
                        err_set   = ~in_win;
                        state_nxt = RLAT;
                    end
                end
            end
            WBURST: begin
                busy    = stall;
                err_set = bus.DDRAM_RD;
                if (bus.DDRAM_WE && !stall) begin
                    wr_acc = 1'b1;
                    mem_we = ~wr_oow;
                    if (beats_left == 8'd1) state_nxt = IDLE;
                end
            end
            RLAT: begin
                busy = 1'b1;
                // First BRAM read issues one cycle before the first beat is due.
                if (lat_sr[RD_LATENCY-2]) begin
                    mem_re    = 1'b1;
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                busy  = 1'b1;
                ready = 1'b1;
                if (beats_left > 8'd1) mem_re = 1'b1;
                else                   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beats_left <= '0;
            addr_cnt   <= '0;
            lat_sr     <= '0;
            stall_cnt  <= '0;
            rd_oow     <= 1'b0;
            wr_oow     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err | err_set;
            if (STALL_PERIOD > 1)
                stall_cnt <= stall ? 16'd0 : stall_cnt + 16'd1;
            if (wr_acc && state == IDLE) begin
                addr_cnt   <= bus.DDRAM_ADDR[AW-1:0] + 1'b1;
                beats_left <= bc_eff - 8'd1;
                wr_oow     <= ~in_win;
            end else if (wr_acc) begin
                addr_cnt   <= addr_cnt + 1'b1;
                beats_left <= beats_left - 8'd1;
            end
            if (rd_acc) begin
                addr_cnt   <= bus.DDRAM_ADDR[AW-1:0];
                beats_left <= bc_eff;
                rd_oow     <= ~in_win;
                lat_sr     <= 14'd1;
            end
            if (state == RLAT) lat_sr <= lat_sr << 1;
            if (mem_re) addr_cnt <= addr_cnt + 1'b1;
            if (state == RDATA) beats_left <= beats_left - 8'd1;
        end
    end

    ddram_resp_mem #(.AW(AW)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.DDRAM_DIN),
        .wbe   (bus.DDRAM_BE),
        .re    (mem_re),
        .raddr (addr_cnt),
        .rdata (mem_q)
    );

    assign bus.DDRAM_BUSY       = busy;
    assign bus.DDRAM_DOUT_READY = ready;
    assign bus.DDRAM_DOUT       = rd_oow ? 64'd0 : mem_q;

endmodule

// File: tb/tb_ddram_bram_responder.sv
// tb/tb_ddram_bram_responder.sv - self-checking bench for ddram_bram_responder
module tb_ddram_bram_responder;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    ddram_bram_responder_if bus ();

    ddram_bram_responder #(
        .AW(10), .BASE_HI(4'b0011), .RD_LATENCY(L), .STALL_PERIOD(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] ref_mem [1024];
    logic [7:0]  kb      [1024];
    logic [63:0] wdat    [16];
    logic [7:0]  wbe     [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] kmask(input int idx);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{kb[idx][b]}};
        return m;
    endfunction

    // rd_flag: 0 none, 1 RD with first beat, 2 RD held during second beat.
    task automatic do_write(input logic [28:0] addr, input int n, input logic [7:0] bc_field,
                            input int rd_flag, output int busy_seen);
        int t;
        busy_seen = 0;
        for (int i = 0; i < n; i++) begin
            bus.DDRAM_WE  = 1'b1;
            bus.DDRAM_DIN = wdat[i];
            bus.DDRAM_BE  = wbe[i];
            bus.DDRAM_RD  = (rd_flag == 1 && i == 0) || (rd_flag == 2 && i == 1);
            if (i == 0) begin
                bus.DDRAM_ADDR     = addr;
                bus.DDRAM_BURSTCNT = bc_field;
            end
            t = 0;
            while (bus.DDRAM_BUSY === 1'b1 && t < 40) begin
                busy_seen++;
                step();
                t++;
            end
            checks++;
            if (bus.DDRAM_BUSY !== 1'b0) begin
                failures++;
                $display("FAIL write_accept beat %0d busy=%b required=0", i, bus.DDRAM_BUSY);
            end
            step();
            if (addr[28:25] == 4'b0011) begin
                int idx = (int'(addr[9:0]) + i) % 1024;
                for (int b = 0; b < 8; b++) begin
                    if (wbe[i][b]) begin
                        ref_mem[idx][8*b +: 8] = wdat[i][8*b +: 8];
                        kb[idx][b] = 1'b1;
                    end
                end
            end
        end
        bus.DDRAM_WE = 1'b0;
        bus.DDRAM_RD = 1'b0;
    endtask

    task automatic do_read(input logic [28:0] addr, input logic [7:0] bc_field, input string name);
        int n = (bc_field == 8'd0) ? 1 : int'(bc_field);
        bit oow = (addr[28:25] != 4'b0011);
        logic [63:0] exp_d, mask, last_d, last_m;
        int t = 0;
        last_d = '0;
        last_m = '0;
        bus.DDRAM_RD = 1'b1;
        bus.DDRAM_WE = 1'b0;
        bus.DDRAM_ADDR = addr;
        bus.DDRAM_BURSTCNT = bc_field;
        while (bus.DDRAM_BUSY === 1'b1 && t < 40) begin step(); t++; end
        checks++;
        if (bus.DDRAM_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s read_accept busy=%b required=0", name, bus.DDRAM_BUSY);
        end
        step();
        bus.DDRAM_RD = 1'b0;
        for (int k = 1; k <= L + n; k++) begin
            bit exp_rdy = (k >= L) && (k < L + n);
            checks++;
            if (bus.DDRAM_DOUT_READY !== exp_rdy) begin
                failures++;
                $display("FAIL %s ready cycle %0d got=%b required=%b", name, k, bus.DDRAM_DOUT_READY, exp_rdy);
            end
            if (k < L + n) begin
                checks++;
                if (bus.DDRAM_BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy cycle %0d got=%b required=1", name, k, bus.DDRAM_BUSY);
                end
            end
            if (exp_rdy) begin
                int idx = (int'(addr[9:0]) + k - L) % 1024;
                exp_d = oow ? 64'd0 : ref_mem[idx];
                mask  = oow ? '1 : kmask(idx);
                checks++;
                if ((bus.DDRAM_DOUT & mask) !== (exp_d & mask)) begin
                    failures++;
                    $display("FAIL %s data beat %0d got=%h required=%h", name, k - L, bus.DDRAM_DOUT & mask, exp_d & mask);
                end
                last_d = exp_d;
                last_m = mask;
            end
            if (k == L + n) begin
                checks++;
                if ((bus.DDRAM_DOUT & last_m) !== (last_d & last_m)) begin
                    failures++;
                    $display("FAIL %s dout_hold got=%h required=%h", name, bus.DDRAM_DOUT & last_m, last_d & last_m);
                end
            end
            step();
        end
    endtask

    task automatic check_err(input logic want, input string name);
        checks++;
        if (err !== want) begin
            failures++;
            $display("FAIL %s err got=%b required=%b", name, err, want);
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (bus.DDRAM_BUSY !== 1'b0)       begin failures++; $display("FAIL reset busy got=%b required=0", bus.DDRAM_BUSY); end
        if (bus.DDRAM_DOUT_READY !== 1'b0) begin failures++; $display("FAIL reset ready got=%b required=0", bus.DDRAM_DOUT_READY); end
        if (bus.DDRAM_DOUT !== 64'd0)      begin failures++; $display("FAIL reset dout got=%h required=0", bus.DDRAM_DOUT); end
        if (err !== 1'b0)                  begin failures++; $display("FAIL reset err got=%b required=0", err); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_be();
        int bs;
        wdat[0] = 64'd0;                 wbe[0] = 8'hFF;
        do_write(29'h6000005, 1, 8'd1, 0, bs);
        wdat[0] = 64'h1122334455667788;  wbe[0] = 8'h0F;
        do_write(29'h6000005, 1, 8'd1, 0, bs);
        checks++;
        if (ref_mem[5] !== 64'h0000000055667788) begin
            failures++;
            $display("FAIL be_model got=%h required=%h", ref_mem[5], 64'h0000000055667788);
        end
        do_read(29'h6000005, 8'd1, "single_be");
        check_err(1'b0, "single_be");
    endtask

    task automatic test_wrap();
        int bs;
        for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wbe[i] = 8'hFF; end
        do_write(29'h60003FE, 4, 8'd4, 0, bs);
        do_read(29'h60003FE, 8'd4, "wrap");
    endtask

    task automatic test_random();
        int bs;
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 6);
            logic [9:0] lo = 10'($urandom);
            for (int i = 0; i < n; i++) begin wdat[i] = {$urandom, $urandom}; wbe[i] = 8'($urandom); end
            do_write({4'b0011, 15'($urandom), lo}, n, 8'(n), 0, bs);
            do_read({4'b0011, 15'($urandom), lo}, 8'($urandom_range(1, n)), "random");
        end
        check_err(1'b0, "random");
    endtask

    task automatic test_stall();
        int bs;
        logic [28:0] a = {4'b0011, 15'd0, 10'($urandom)};
        for (int i = 0; i < 8; i++) begin wdat[i] = {$urandom, $urandom}; wbe[i] = 8'hFF; end
        do_write(a, 8, 8'd8, 0, bs);
        checks++;
        if (bs == 0) begin
            failures++;
            $display("FAIL stall busy_cycles got=%0d required=>0", bs);
        end
        do_read(a, 8'd8, "stall");
    endtask

    task automatic test_out_of_window();
        int bs;
        check_err(1'b0, "oow_before");
        for (int i = 0; i < 2; i++) begin wdat[i] = {$urandom, $urandom}; wbe[i] = 8'hFF; end
        do_write(29'h6000010, 2, 8'd2, 0, bs);
        for (int i = 0; i < 2; i++) begin wdat[i] = ~wdat[i]; end
        do_write(29'h1000010, 2, 8'd2, 0, bs);
        check_err(1'b1, "oow_write");
        do_read(29'h1000010, 8'd2, "oow_read");
        do_read(29'h6000010, 8'd2, "oow_unchanged");
    endtask

    task automatic test_reset_mid_read();
        int bs;
        int t = 0;
        logic [28:0] a = 29'h6000100;
        rst_n = 1'b0;
        step();
        check_err(1'b0, "rst_clears_err");
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin wdat[i] = {$urandom, $urandom}; wbe[i] = 8'hFF; end
        do_write(a, 8, 8'd8, 0, bs);
        bus.DDRAM_RD = 1'b1; bus.DDRAM_ADDR = a; bus.DDRAM_BURSTCNT = 8'd8;
        while (bus.DDRAM_BUSY === 1'b1 && t < 40) begin step(); t++; end
        step();
        bus.DDRAM_RD = 1'b0;
        step(); step(); step();
        checks++;
        if (bus.DDRAM_DOUT_READY !== 1'b1) begin
            failures++;
            $display("FAIL midread ready_before_reset got=%b required=1", bus.DDRAM_DOUT_READY);
        end
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks += 2;
            if (bus.DDRAM_DOUT_READY !== 1'b0) begin failures++; $display("FAIL midread ready got=%b required=0", bus.DDRAM_DOUT_READY); end
            if (bus.DDRAM_BUSY !== 1'b0)       begin failures++; $display("FAIL midread busy got=%b required=0", bus.DDRAM_BUSY); end
            step();
        end
        rst_n = 1'b1;
        step();
        do_read(a, 8'd8, "after_reset");
    endtask

    task automatic test_rd_we_and_bc0();
        int bs;
        wdat[0] = {$urandom, $urandom}; wbe[0] = 8'hFF;
        do_write(29'h6000200, 1, 8'd1, 1, bs);
        for (int c = 0; c < L + 3; c++) begin
            checks++;
            if (bus.DDRAM_DOUT_READY !== 1'b0) begin
                failures++;
                $display("FAIL rdwe dropped_read ready got=%b required=0", bus.DDRAM_DOUT_READY);
            end
            step();
        end
        check_err(1'b1, "rdwe");
        do_read(29'h6000200, 8'd1, "rdwe_data");
        do_read(29'h6000200, 8'd0, "bc0");
    endtask

    task automatic test_rd_in_wburst();
        int bs;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin wdat[i] = {$urandom, $urandom}; wbe[i] = 8'hFF; end
        do_write(29'h6000300, 3, 8'd3, 2, bs);
        check_err(1'b1, "rd_in_wburst");
        do_read(29'h6000300, 8'd3, "rd_in_wburst_data");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; kb[i] = '0; end
        bus.DDRAM_RD = 1'b0; bus.DDRAM_WE = 1'b0; bus.DDRAM_ADDR = '0;
        bus.DDRAM_BURSTCNT = '0; bus.DDRAM_DIN = '0; bus.DDRAM_BE = '0;
        test_reset();
        test_single_be();
        test_wrap();
        test_random();
        test_stall();
        test_out_of_window();
        test_reset_mid_read();
        test_rd_we_and_bc0();
        test_rd_in_wburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1);
    end

endmodule
